ntt_butterfly_addsub: RTL and testbench
=======================================

Name: ntt_butterfly_addsub

Overview:
Final stage of the Kyber NTT/INTT butterfly datapath, directly downstream of the Barrett reducer.
- Consumes the reduced twiddle product r = (b·ζ) mod q from the reducer.
- Realigns the companion operand a, which was issued BARRETT_LAT cycles earlier.
- Produces the butterfly pair x = (a+r) mod q and y = (a−r) mod q, halved mod q in INTT mode.
- Buffers results in a small FIFO with valid/ready output. Issue is credit-gated because the reducer pipeline cannot stall.

Parameters:
BARRETT_LAT, 2, cycles from product entering the reducer to r_i valid; length of the operand delay line.
FIFO_DEPTH, 4, output FIFO entries; power of two, ≥2.
TAG_W, 8, width of the opaque tag (coefficient address) carried with each butterfly.

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  asynchronous, active-high reset.
issue_valid_i  in  1  butterfly issued this cycle; its product enters the reducer this same cycle.
issue_ready_o  out  1  credit available; issue is legal only when high.
a_i  in  12  operand a, canonical [0,q).
mode_i  in  1  0 = NTT (CT), 1 = INTT (apply ½ mod q to both outputs).
tag_i  in  TAG_W  tag travelling with the butterfly.
r_i  in  13  reducer output, sampled BARRETT_LAT cycles after issue.
out_valid_o  out  1  FIFO head valid.
out_ready_i  in  1  consumer accepts head.
x_o  out  12  (a+r) mod q, halved if INTT.
y_o  out  12  (a−r) mod q, halved if INTT.
tag_o  out  TAG_W  tag of head entry.
err_o  out  1  sticky error flag.

Behaviour:
- Shared constant: Q = 3329. All arithmetic is unsigned, 13-bit internal, results in [0,Q).
- Delay line: BARRETT_LAT-deep shift register of {valid, a, mode, tag}, loaded every cycle with {issue_valid_i & issue_ready_o, a_i, mode_i, tag_i}. Its output aligns with r_i.
- Issue with issue_ready_o low is ignored: a valid bit of 0 enters the delay line.
- Combinational compute on aligned data:
  - s = a + r; x' = (s ≥ Q) ? s−Q : s.
  - d = a − r; if negative (13-bit borrow) d + Q, else d; result is y'.
- INTT halving, per value v: v[0] ? (v+Q)>>1 : v>>1. Result stays < Q.
- FIFO write: the aligned-valid result is written at the end of the same cycle.
  - Issue at cycle t → r_i sampled at t+BARRETT_LAT → out_valid_o high at t+BARRETT_LAT+1 (3 cycles, empty FIFO).
- FIFO: synchronous, registered head, no fall-through. Pop when out_valid_o & out_ready_i.
  - Simultaneous push and pop while full is legal: count unchanged.
  - Push while full without a pop: the entry is dropped and err_o is set.
  - Pointers wrap modulo FIFO_DEPTH. Order is strictly preserved.
- Credits: inflight = popcount of delay-line valid bits. issue_ready_o = (count + inflight) < FIFO_DEPTH.
  - A pop in the current cycle is not credited until the next cycle (conservative, registered count).
- err_o (sticky until reset) is set by any of:
  - overflow drop;
  - aligned-valid r_i ≥ Q;
  - aligned-valid a ≥ Q.
  Out-of-range data is still computed and pushed; no saturation.
- Reset (asynchronous, any time including mid-operation):
  - delay line valid bits, FIFO pointers and count, and err_o clear to 0;
  - out_valid_o = 0, issue_ready_o = 1 after reset deassertion;
  - x_o, y_o, tag_o = 0;
  - in-flight butterflies are discarded.
- r_i is ignored in cycles where the aligned valid bit is 0.

Decomposition:
- Package ntt_pkg holds:
  - Q = 3329, COEF_W = 12, RED_W = 13;
  - typedef coef_t (12-bit), typedef butterfly_t {coef_t x, y; tag};
  - function mod_half(coef_t) returning ½·v mod Q.
- One natural sub-module: ntt_sync_fifo (parameterised width/depth, count output), reusable elsewhere in the NTT controller.

Test Plan:
- NTT, FIFO empty, out_ready_i=1: issue a=100 at t, drive r_i=200 at t+2 → out_valid_o at t+3 with x=300, y=3229; err_o=0.
- NTT wrap: a=3000, r=1000 → x=671, y=2000. Also a=0, r=0 → x=0, y=0. Also a=3328, r=3328 → x=3327, y=0.
- INTT halving: mode=1, a=3, r=0 → x=1666, y=1666. Then a=10, r=4 → x=7, y=3.
- Backpressure: out_ready_i=0, issue every cycle → exactly 4 issues accepted, issue_ready_o low from the cycle after the 4th issue. Raise out_ready_i → outputs drain in tag order 0,1,2,3, and issue_ready_o returns one cycle after the first pop.
- Error paths: r_i=3400 with aligned valid → err_o set next cycle and stays set. Separately, force issue while issue_ready_o=0 → no extra entry appears and err_o stays 0.
- Reset mid-operation: 2 butterflies in the delay line plus 2 in the FIFO, assert rst_i asynchronously between edges → out_valid_o drops immediately, no stale outputs after release, issue_ready_o=1.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared constants, types and helpers for the Kyber NTT butterfly datapath.
package ntt_pkg;

    localparam int unsigned Q        = 3329;
    localparam int unsigned COEF_W   = 12;
    localparam int unsigned RED_W    = 13;
    localparam int unsigned BF_TAG_W = 8;

    typedef logic [COEF_W-1:0] coef_t;
    typedef logic [RED_W-1:0]  red_t;

    typedef struct packed {
        coef_t                x;
        coef_t                y;
        logic [BF_TAG_W-1:0]  tag;
    } butterfly_t;

    // Multiply by the inverse of 2 mod Q: odd values borrow a Q to become even first.
    function automatic coef_t mod_half(input coef_t v);
        red_t t;
        t = v[0] ? (red_t'(v) + red_t'(Q)) : red_t'(v);
        return coef_t'(t >> 1);
    endfunction

endpackage

// File: rtl/ntt_sync_fifo.sv
// Synchronous FIFO with registered head, occupancy count and overflow-drop indication.
module ntt_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] rdata,
    output logic [AW:0]      count,
    output logic             overflow
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign full     = (cnt == (AW+1)'(DEPTH));
    assign valid    = (cnt != '0);
    assign do_pop   = pop & valid;
    // A pop in the same cycle frees the slot the push lands in.
    assign do_push  = push & (~full | do_pop);
    assign overflow = push & full & ~do_pop;
    assign count    = cnt;
    assign rdata    = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/ntt_butterfly_addsub.sv
// Butterfly add/sub stage: realigns operand a with the reducer output, forms (a+r, a-r) mod Q,
// optionally halves for INTT, and buffers results behind a credit-gated issue interface.
module ntt_butterfly_addsub
    import ntt_pkg::*;
#(
    parameter int unsigned BARRETT_LAT = 2,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned TAG_W       = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             issue_valid_i,
    output logic             issue_ready_o,
    input  logic [11:0]      a_i,
    input  logic             mode_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic [12:0]      r_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [11:0]      x_o,
    output logic [11:0]      y_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             err_o
);

    localparam int unsigned DW  = 2 * COEF_W + TAG_W;
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CRW = AW + $clog2(BARRETT_LAT + 1) + 1;

    logic [BARRETT_LAT-1:0] dl_valid;
    logic [BARRETT_LAT-1:0] dl_mode;
    coef_t                  dl_a   [BARRETT_LAT];
    logic [TAG_W-1:0]       dl_tag [BARRETT_LAT];

    logic             issue_fire;
    logic             al_valid;
    logic             al_mode;
    coef_t            al_a;
    logic [TAG_W-1:0] al_tag;

    red_t  sum;
    red_t  diff;
    red_t  diff_q;
    logic  borrow;
    coef_t x_raw;
    coef_t y_raw;
    coef_t x_res;
    coef_t y_res;

    logic [CRW-1:0] inflight;
    logic [AW:0]    fifo_count;
    logic           overflow;
    logic           range_err;
    logic           err_q;
    logic [DW-1:0]  head;

    assign issue_fire = issue_valid_i & issue_ready_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dl_valid <= '0;
        end else begin
            dl_valid[0] <= issue_fire;
            for (int i = 1; i < BARRETT_LAT; i++) begin
                dl_valid[i] <= dl_valid[i-1];
            end
        end
    end

    // Payload needs no reset: it is only consumed alongside a set valid bit.
    always_ff @(posedge clk_i) begin
        dl_a[0]    <= a_i;
        dl_mode[0] <= mode_i;
        dl_tag[0]  <= tag_i;
        for (int i = 1; i < BARRETT_LAT; i++) begin
            dl_a[i]    <= dl_a[i-1];
            dl_mode[i] <= dl_mode[i-1];
            dl_tag[i]  <= dl_tag[i-1];
        end
    end

    assign al_valid = dl_valid[BARRETT_LAT-1];
    assign al_mode  = dl_mode[BARRETT_LAT-1];
    assign al_a     = dl_a[BARRETT_LAT-1];
    assign al_tag   = dl_tag[BARRETT_LAT-1];

    always_comb begin
        sum    = red_t'(al_a) + r_i;
        x_raw  = (sum >= red_t'(Q)) ? coef_t'(sum - red_t'(Q)) : coef_t'(sum);
        diff   = red_t'(al_a) - r_i;
        borrow = (red_t'(al_a) < r_i);
        diff_q = diff + red_t'(Q);
        y_raw  = borrow ? coef_t'(diff_q) : coef_t'(diff);
        x_res  = al_mode ? mod_half(x_raw) : x_raw;
        y_res  = al_mode ? mod_half(y_raw) : y_raw;
    end

    // Credits count registered FIFO occupancy plus everything still in the reducer.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < BARRETT_LAT; i++) begin
            inflight = inflight + CRW'(dl_valid[i]);
        end
    end

    assign issue_ready_o = (CRW'(fifo_count) + inflight) < CRW'(FIFO_DEPTH);

    assign range_err = al_valid & ((r_i >= red_t'(Q)) | (red_t'(al_a) >= red_t'(Q)));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (overflow | range_err) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;

    ntt_sync_fifo #(
        .WIDTH (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk_i),
        .rst      (rst_i),
        .push     (al_valid),
        .wdata    ({x_res, y_res, al_tag}),
        .pop      (out_ready_i),
        .valid    (out_valid_o),
        .rdata    (head),
        .count    (fifo_count),
        .overflow (overflow)
    );

    assign {x_o, y_o, tag_o} = head;

endmodule

// File: tb/tb_ntt_butterfly_addsub.sv
// Self-checking bench for ntt_butterfly_addsub: behavioural scoreboard model plus directed cases.
module tb_ntt_butterfly_addsub;

    localparam int LAT   = 2;
    localparam int DEPTH = 4;
    localparam int TW    = 8;
    localparam int QV    = 3329;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          issue_valid = 1'b0;
    logic          issue_ready;
    logic [11:0]   a_in = '0;
    logic          mode_in = 1'b0;
    logic [TW-1:0] tag_in = '0;
    logic [12:0]   r_in = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [11:0]   x_out;
    logic [11:0]   y_out;
    logic [TW-1:0] tag_out;
    logic          err;

    always #5 clk = ~clk;

    ntt_butterfly_addsub #(
        .BARRETT_LAT (LAT),
        .FIFO_DEPTH  (DEPTH),
        .TAG_W       (TW)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .issue_valid_i (issue_valid),
        .issue_ready_o (issue_ready),
        .a_i           (a_in),
        .mode_i        (mode_in),
        .tag_i         (tag_in),
        .r_i           (r_in),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .x_o           (x_out),
        .y_o           (y_out),
        .tag_o         (tag_out),
        .err_o         (err)
    );

    typedef struct { bit v; int a; int r; bit m; int tag; } iss_t;
    typedef struct { int x; int y; int tag; } res_t;

    iss_t pipe [LAT];
    res_t fq [$];
    bit   m_err = 1'b0;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int half(input int v);
        return (v % 2 == 1) ? (v + QV) / 2 : v / 2;
    endfunction

    // 13-bit internal arithmetic, 12-bit results.
    task automatic model_bf(input int a, input int r, input bit m, output int x, output int y);
        int s;
        int d;
        s = (a + r) % 8192;
        x = ((s >= QV) ? s - QV : s) % 4096;
        if (a < r) d = ((a - r + QV) % 8192 + 8192) % 8192;
        else       d = a - r;
        y = d % 4096;
        if (m) begin
            x = half(x);
            y = half(y);
        end
    endtask

    function automatic bit model_ready();
        int inf;
        inf = 0;
        for (int i = 0; i < LAT; i++) if (pipe[i].v) inf++;
        return (fq.size() + inf) < DEPTH;
    endfunction

    task automatic model_clear();
        fq.delete();
        for (int i = 0; i < LAT; i++) pipe[i] = '{1'b0, 0, 0, 1'b0, 0};
        m_err = 1'b0;
    endtask

    // Called at posedge+1; drives one cycle, checks mid-cycle, updates the model at the edge.
    task automatic step(input bit iv, input int a, input bit m, input int tag, input int r,
                        input bit ordy);
        bit   acc;
        bit   pop;
        bit   full;
        res_t res;
        issue_valid = iv;
        a_in        = 12'(a);
        mode_in     = m;
        tag_in      = TW'(tag);
        out_ready   = ordy;
        r_in        = pipe[LAT-1].v ? 13'(pipe[LAT-1].r) : 13'($urandom_range(0, 8191));
        @(negedge clk);
        chk("issue_ready", int'(issue_ready), int'(model_ready()));
        chk("out_valid", int'(out_valid), int'(fq.size() != 0));
        if (fq.size() != 0) begin
            chk("x", int'(x_out), fq[0].x);
            chk("y", int'(y_out), fq[0].y);
            chk("tag", int'(tag_out), fq[0].tag);
        end
        chk("err", int'(err), int'(m_err));
        @(posedge clk);
        acc  = iv && model_ready();
        pop  = (fq.size() != 0) && ordy;
        full = (fq.size() == DEPTH);
        if (pipe[LAT-1].v) begin
            model_bf(pipe[LAT-1].a, pipe[LAT-1].r, pipe[LAT-1].m, res.x, res.y);
            res.tag = pipe[LAT-1].tag;
            if (pipe[LAT-1].r >= QV || pipe[LAT-1].a >= QV) m_err = 1'b1;
        end
        if (pop) void'(fq.pop_front());
        if (pipe[LAT-1].v) begin
            if (full && !pop) m_err = 1'b1;
            else              fq.push_back(res);
        end
        for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0] = '{acc, a % 4096, r, m, tag % 256};
        #1;
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 0, 0, ordy);
    endtask

    // Asynchronous reset asserted between edges; called and returns at posedge+1.
    task automatic reset_async();
        issue_valid = 1'b0;
        out_ready   = 1'b0;
        #3 rst = 1'b1;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_issue_ready", int'(issue_ready), 1);
        chk("rst_err", int'(err), 0);
        chk("rst_x", int'(x_out), 0);
        chk("rst_y", int'(y_out), 0);
        chk("rst_tag", int'(tag_out), 0);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    int pa [6] = '{100, 3000, 0, 3328, 3, 10};
    int pr [6] = '{200, 1000, 0, 3328, 0, 4};
    bit pm [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int px [6] = '{300, 671, 0, 3327, 1666, 7};
    int py [6] = '{3229, 2000, 0, 0, 1666, 3};

    initial begin
        int mx;
        int my;
        model_clear();

        for (int i = 0; i < 6; i++) begin
            model_bf(pa[i], pr[i], pm[i], mx, my);
            chk("pin_x", mx, px[i]);
            chk("pin_y", my, py[i]);
        end

        #12;
        chk("init_out_valid", int'(out_valid), 0);
        chk("init_issue_ready", int'(issue_ready), 1);
        chk("init_err", int'(err), 0);
        chk("init_x", int'(x_out), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // First-result latency on an empty FIFO.
        step(1'b1, 100, 1'b0, 8'h11, 200, 1'b1);
        idle(2, 1'b1);
        chk("lat_valid", int'(out_valid), 1);
        chk("lat_x", int'(x_out), 300);
        chk("lat_y", int'(y_out), 3229);
        chk("lat_tag", int'(tag_out), 8'h11);
        idle(3, 1'b1);

        for (int i = 1; i < 6; i++) step(1'b1, pa[i], pm[i], 8'h20 + i, pr[i], 1'b1);
        idle(5, 1'b1);

        // Backpressure: only DEPTH issues accepted, later attempts dropped by the credit gate.
        for (int k = 0; k < 7; k++)
            step(1'b1, $urandom_range(0, QV - 1), 1'b0, k, $urandom_range(0, QV - 1), 1'b0);
        chk("bp_ready_low", int'(issue_ready), 0);
        chk("bp_head_tag", int'(tag_out), 0);
        idle(7, 1'b1);

        for (int n = 0; n < 500; n++)
            step($urandom_range(0, 9) < 7, $urandom_range(0, QV - 1), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 255), $urandom_range(0, QV - 1), $urandom_range(0, 9) < 6);
        idle(8, 1'b1);

        // Two entries in the FIFO and two in the delay line, then reset mid-operation.
        for (int k = 0; k < 4; k++)
            step(1'b1, $urandom_range(0, QV - 1), 1'b0, 8'h40 + k, $urandom_range(0, QV - 1),
                 1'b0);
        reset_async();
        for (int n = 0; n < 30; n++)
            step($urandom_range(0, 9) < 7, $urandom_range(0, QV - 1), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 255), $urandom_range(0, QV - 1), 1'b1);
        idle(6, 1'b1);

        // Out-of-range reducer output flags a sticky error but is still pushed.
        step(1'b1, 100, 1'b0, 8'h55, 3400, 1'b1);
        idle(6, 1'b1);
        chk("err_r_sticky", int'(err), 1);
        reset_async();

        step(1'b1, 4000, 1'b0, 8'h66, 10, 1'b1);
        idle(6, 1'b1);
        chk("err_a_sticky", int'(err), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
